// File: rtl/wjbot_riscv.sv
// Shared package for the test-vector response checker.
//   tvchk_state_t : checker run state (idle, running, finished)
//   tvchk_fold    : XOR of the HW-bit chunks of a word. The caller zero-pads
//                   its word into the 256-bit argument and passes its HW; the
//                   result carries the folded value in its low HW bits.
package wjbot_riscv;

  typedef enum logic [1:0] {TVCHK_IDLE, TVCHK_RUN, TVCHK_DONE} tvchk_state_t;

  localparam int TVCHK_FOLD_MAX_W  = 256;
  localparam int TVCHK_FOLD_MAX_HW = 64;

  // Bit i of the word lands in chunk position (i mod hw). Walking the bits
  // with a wrapping position keeps this free of division.
  function automatic logic [TVCHK_FOLD_MAX_HW-1:0] tvchk_fold(
    input logic [TVCHK_FOLD_MAX_W-1:0] m,
    input int                          hw
  );
    logic [TVCHK_FOLD_MAX_HW-1:0] f;
    int pos;
    f   = '0;
    pos = 0;
    for (int i = 0; i < TVCHK_FOLD_MAX_W; i++) begin
      f[pos[5:0]] = f[pos[5:0]] ^ m[i[7:0]];
      pos = (pos == hw - 1) ? 0 : pos + 1;
    end
    return f;
  endfunction

endpackage

// File: rtl/tvchk_signature.sv
// Running signature register for the response checker.
// Folds the cared DUT bits into HW bits, XORs them into the signature, then
// rotates left by one bit. The new bit 0 is the XOR of the top two bits.
// Ports:
//   clk, reset : clock and synchronous active-low reset
//   clear_i    : zero the signature (takes priority over en_i)
//   en_i       : absorb m_i this cycle
//   m_i  [W]   : cared word (obs & care)
//   hash_o [HW]: current signature
module tvchk_signature
  import wjbot_riscv::*;
#(
  parameter int W  = 16,
  parameter int HW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          en_i,
  input  logic [W-1:0]  m_i,
  output logic [HW-1:0] hash_o
);

  logic [TVCHK_FOLD_MAX_W-1:0] mPad;
  logic [HW-1:0] fold;
  logic [HW-1:0] h1;
  logic [HW-1:0] hash_d;
  logic [HW-1:0] hash_q;

  // Fold the padded word, mix it into the signature, then rotate with feedback.
  always_comb begin
    mPad         = '0;
    mPad[W-1:0]  = m_i;
    fold         = HW'(tvchk_fold(mPad, HW));
    h1           = hash_q ^ fold;
    hash_d       = {h1[HW-2:0], h1[HW-1] ^ h1[HW-2]};
  end

  // Signature register. Clear wins over update so a restart never leaks old data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hash_q <= '0;
    end else if (clear_i) begin
      hash_q <= '0;
    end else if (en_i) begin
      hash_q <= hash_d;
    end
  end

  assign hash_o = hash_q;

endmodule

// File: rtl/tv_response_checker.sv
// Response checker for vector-driven unit benches.
// Compares obs against exp_val under exp_care, counts accepted and failing
// vectors (both saturating), and keeps a running signature of the cared
// obs bits.
// Optional feature macro: TVCHK_FIRST_ERR_EN adds first-error capture ports.
// Ports:
//   clk, reset       : clock, synchronous active-low reset
//   start            : begin or restart a run (dominates a same-cycle vector)
//   vec_valid/last   : vector strobe and end-of-run marker
//   obs/exp_val/care : observed word, expected word, per-bit care mask
//   busy/done/pass   : run state and final verdict
//   mismatch(_bits)  : registered result of the previous accepted vector
//   vec_count        : accepted vector counter
//   err_count        : failing vector counter
//   hash             : running signature
//   first_err_*      : index and diff of the first failing vector (optional)
module tv_response_checker
  import wjbot_riscv::*;
#(
  parameter int W  = 16,
  parameter int HW = 7,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          vec_valid,
  input  logic          vec_last,
  input  logic [W-1:0]  obs,
  input  logic [W-1:0]  exp_val,
  input  logic [W-1:0]  exp_care,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          mismatch,
  output logic [W-1:0]  mismatch_bits,
  output logic [CW-1:0] vec_count,
  output logic [CW-1:0] err_count,
  output logic [HW-1:0] hash
`ifdef TVCHK_FIRST_ERR_EN
  ,
  output logic          first_err_valid,
  output logic [CW-1:0] first_err_idx,
  output logic [W-1:0]  first_err_bits
`endif
);

  tvchk_state_t state_q, state_d;
  logic          clearRun;
  logic          accept;
  logic [W-1:0]  diff;
  logic          fail;
  logic [CW-1:0] vecCount_q, vecCount_d;
  logic [CW-1:0] errCount_q, errCount_d;
  logic          mismatch_q, mismatch_d;
  logic [W-1:0]  mismatchBits_q, mismatchBits_d;

  assign diff = (obs ^ exp_val) & exp_care;
  assign fail = |diff;

  // Run FSM. A start from any state (re)enters RUN and drops a same-cycle vector.
  always_comb begin
    state_d  = state_q;
    clearRun = 1'b0;
    accept   = 1'b0;
    if (start) begin
      state_d  = TVCHK_RUN;
      clearRun = 1'b1;
    end else begin
      case (state_q)
        TVCHK_RUN: begin
          if (vec_valid) begin
            accept = 1'b1;
            if (vec_last) state_d = TVCHK_DONE;
          end
        end
        TVCHK_IDLE, TVCHK_DONE: state_d = state_q;
        default: state_d = TVCHK_IDLE;
      endcase
    end
  end

  // Counters and per-vector result. The result pulse is zero unless a vector
  // was accepted on the previous edge.
  always_comb begin
    vecCount_d     = vecCount_q;
    errCount_d     = errCount_q;
    mismatch_d     = 1'b0;
    mismatchBits_d = '0;
    if (clearRun) begin
      vecCount_d = '0;
      errCount_d = '0;
    end else if (accept) begin
      if (vecCount_q != {CW{1'b1}}) vecCount_d = vecCount_q + CW'(1);
      if (fail && (errCount_q != {CW{1'b1}})) errCount_d = errCount_q + CW'(1);
      mismatch_d     = fail;
      mismatchBits_d = diff;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= TVCHK_IDLE;
      vecCount_q     <= '0;
      errCount_q     <= '0;
      mismatch_q     <= 1'b0;
      mismatchBits_q <= '0;
    end else begin
      state_q        <= state_d;
      vecCount_q     <= vecCount_d;
      errCount_q     <= errCount_d;
      mismatch_q     <= mismatch_d;
      mismatchBits_q <= mismatchBits_d;
    end
  end

  tvchk_signature #(.W(W), .HW(HW)) uSignature (
    .clk     (clk),
    .reset   (reset),
    .clear_i (clearRun),
    .en_i    (accept),
    .m_i     (obs & exp_care),
    .hash_o  (hash)
  );

`ifdef TVCHK_FIRST_ERR_EN
  logic          firstErrValid_q, firstErrValid_d;
  logic [CW-1:0] firstErrIdx_q, firstErrIdx_d;
  logic [W-1:0]  firstErrBits_q, firstErrBits_d;

  // Latch the pre-increment index and diff of the first failure, hold until restart.
  always_comb begin
    firstErrValid_d = firstErrValid_q;
    firstErrIdx_d   = firstErrIdx_q;
    firstErrBits_d  = firstErrBits_q;
    if (clearRun) begin
      firstErrValid_d = 1'b0;
      firstErrIdx_d   = '0;
      firstErrBits_d  = '0;
    end else if (accept && fail && !firstErrValid_q) begin
      firstErrValid_d = 1'b1;
      firstErrIdx_d   = vecCount_q;
      firstErrBits_d  = diff;
    end
  end

  // First-error registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      firstErrValid_q <= 1'b0;
      firstErrIdx_q   <= '0;
      firstErrBits_q  <= '0;
    end else begin
      firstErrValid_q <= firstErrValid_d;
      firstErrIdx_q   <= firstErrIdx_d;
      firstErrBits_q  <= firstErrBits_d;
    end
  end

  assign first_err_valid = firstErrValid_q;
  assign first_err_idx   = firstErrIdx_q;
  assign first_err_bits  = firstErrBits_q;
`endif

  assign busy          = (state_q == TVCHK_RUN);
  assign done          = (state_q == TVCHK_DONE);
  assign pass          = (state_q == TVCHK_DONE) && (errCount_q == '0);
  assign mismatch      = mismatch_q;
  assign mismatch_bits = mismatchBits_q;
  assign vec_count     = vecCount_q;
  assign err_count     = errCount_q;

endmodule

// File: tb/tb_tv_response_checker.sv
// Self-checking bench for tv_response_checker (W=16, HW=7).
// A second instance with CW=4 shares the stimulus to observe counter saturation.
// Expected results come from a behavioural model, queued when stimulus is
// driven and compared one cycle later.
module tb_tv_response_checker;

  typedef struct {
    logic        rst;
    logic        st;
    logic        vv;
    logic        vl;
    logic [15:0] obs;
    logic [15:0] ev;
    logic [15:0] care;
    logic        expMm;
    logic [15:0] expMb;
  } stim_t;

  typedef struct {
    logic        busy;
    logic        done;
    logic        pass;
    logic        mm;
    logic [15:0] mb;
    logic [31:0] vc;
    logic [31:0] ec;
    logic [6:0]  h;
    logic [3:0]  vc4;
    logic [3:0]  ec4;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        vec_valid;
  logic        vec_last;
  logic [15:0] obs;
  logic [15:0] exp_val;
  logic [15:0] exp_care;

  logic        busy, done, pass, mismatch;
  logic [15:0] mismatch_bits;
  logic [31:0] vec_count, err_count;
  logic [6:0]  hash;

  logic        satBusy, satDone, satPass, satMm;
  logic [15:0] satMb;
  logic [3:0]  satVc, satEc;
  logic [6:0]  satHash;

`ifdef TVCHK_FIRST_ERR_EN
  logic        feValid, satFeValid;
  logic [31:0] feIdx;
  logic [3:0]  satFeIdx;
  logic [15:0] feBits, satFeBits;
`endif

  tv_response_checker #(.W(16), .HW(7), .CW(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .vec_valid     (vec_valid),
    .vec_last      (vec_last),
    .obs           (obs),
    .exp_val       (exp_val),
    .exp_care      (exp_care),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .mismatch      (mismatch),
    .mismatch_bits (mismatch_bits),
    .vec_count     (vec_count),
    .err_count     (err_count),
    .hash          (hash)
`ifdef TVCHK_FIRST_ERR_EN
    ,
    .first_err_valid (feValid),
    .first_err_idx   (feIdx),
    .first_err_bits  (feBits)
`endif
  );

  tv_response_checker #(.W(16), .HW(7), .CW(4)) dutSat (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .vec_valid     (vec_valid),
    .vec_last      (vec_last),
    .obs           (obs),
    .exp_val       (exp_val),
    .exp_care      (exp_care),
    .busy          (satBusy),
    .done          (satDone),
    .pass          (satPass),
    .mismatch      (satMm),
    .mismatch_bits (satMb),
    .vec_count     (satVc),
    .err_count     (satEc),
    .hash          (satHash)
`ifdef TVCHK_FIRST_ERR_EN
    ,
    .first_err_valid (satFeValid),
    .first_err_idx   (satFeIdx),
    .first_err_bits  (satFeBits)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checksTotal = 0;
  int checksPassed = 0;
  exp_t expQ[$];

  // Behavioural model state: 0 idle, 1 run, 2 done
  int          mState = 0;
  logic [31:0] mVc = '0, mEc = '0;
  logic [3:0]  mVc4 = '0, mEc4 = '0;
  logic [6:0]  mH = '0;
  logic        mMm = 1'b0;
  logic [15:0] mMb = '0;

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] req);
    checksTotal++;
    if (act === req) checksPassed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Advance the model by one clock edge for the given stimulus.
  task automatic modelStep(input stim_t s, output exp_t e);
    logic [15:0] d;
    logic [20:0] p;
    logic [6:0]  f, h1;
    if (!s.rst) begin
      mState = 0; mVc = '0; mEc = '0; mVc4 = '0; mEc4 = '0; mH = '0; mMm = 1'b0; mMb = '0;
    end else if (s.st) begin
      mState = 1; mVc = '0; mEc = '0; mVc4 = '0; mEc4 = '0; mH = '0; mMm = 1'b0; mMb = '0;
    end else if (mState == 1 && s.vv) begin
      d = (s.obs ^ s.ev) & s.care;
      mMm = (d != 16'h0);
      mMb = d;
      if (mVc != 32'hFFFF_FFFF) mVc = mVc + 1;
      if (mVc4 != 4'hF) mVc4 = mVc4 + 1;
      if (mMm && mEc != 32'hFFFF_FFFF) mEc = mEc + 1;
      if (mMm && mEc4 != 4'hF) mEc4 = mEc4 + 1;
      p  = {5'b0, s.obs & s.care};
      f  = p[6:0] ^ p[13:7] ^ p[20:14];
      h1 = mH ^ f;
      mH = {h1[5:0], h1[6] ^ h1[5]};
      if (s.vl) mState = 2;
    end else begin
      mMm = 1'b0; mMb = '0;
    end
    e.busy = (mState == 1);
    e.done = (mState == 2);
    e.pass = (mState == 2) && (mEc == 0);
    e.mm   = mMm;
    e.mb   = mMb;
    e.vc   = mVc;
    e.ec   = mEc;
    e.h    = mH;
    e.vc4  = mVc4;
    e.ec4  = mEc4;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      checkField("queueEmpty", 32'd1, 32'd0);
      return;
    end
    e = expQ.pop_front();
    checkField("busy", 32'(busy), 32'(e.busy));
    checkField("done", 32'(done), 32'(e.done));
    checkField("pass", 32'(pass), 32'(e.pass));
    checkField("mismatch", 32'(mismatch), 32'(e.mm));
    checkField("mismatchBits", 32'(mismatch_bits), 32'(e.mb));
    checkField("vecCount", vec_count, e.vc);
    checkField("errCount", err_count, e.ec);
    checkField("hash", 32'(hash), 32'(e.h));
    checkField("satVecCount", 32'(satVc), 32'(e.vc4));
    checkField("satErrCount", 32'(satEc), 32'(e.ec4));
  endtask

  task automatic applyStimulus(input stim_t s, input bit useTable);
    exp_t e;
    reset = s.rst; start = s.st; vec_valid = s.vv; vec_last = s.vl;
    obs = s.obs; exp_val = s.ev; exp_care = s.care;
    modelStep(s, e);
    if (useTable) begin
      e.mm = s.expMm;
      e.mb = s.expMb;
    end
    expQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  function automatic stim_t mk(input logic rst, st, vv, vl, input logic [15:0] o, ev, care,
                               input logic expMm, input logic [15:0] expMb);
    stim_t s;
    s.rst = rst; s.st = st; s.vv = vv; s.vl = vl;
    s.obs = o; s.ev = ev; s.care = care; s.expMm = expMm; s.expMb = expMb;
    return s;
  endfunction

  stim_t tbl[13];

  initial begin
    reset = 1'b0; start = 1'b0; vec_valid = 1'b0; vec_last = 1'b0;
    obs = '0; exp_val = '0; exp_care = '0;

    tbl[0]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000); // reset
    tbl[1]  = mk(1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000); // start
    tbl[2]  = mk(1, 0, 1, 0, 16'h1234, 16'h1234, 16'hFFFF, 0, 16'h0000);
    tbl[3]  = mk(1, 0, 1, 0, 16'hABCD, 16'hABCD, 16'hFFFF, 0, 16'h0000);
    tbl[4]  = mk(1, 0, 1, 1, 16'h0F0F, 16'h0F0F, 16'hFFFF, 0, 16'h0000); // last -> done, pass
    tbl[5]  = mk(1, 0, 1, 0, 16'h0000, 16'hFFFF, 16'hFFFF, 0, 16'h0000); // ignored in DONE
    tbl[6]  = mk(1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000); // restart
    tbl[7]  = mk(1, 0, 1, 0, 16'h00F0, 16'h00FF, 16'h00F0, 0, 16'h0000); // differing bits masked
    tbl[8]  = mk(1, 0, 1, 0, 16'h00F0, 16'h00FF, 16'h00FF, 1, 16'h000F); // now cared
    tbl[9]  = mk(1, 0, 0, 1, 16'hFFFF, 16'h0000, 16'hFFFF, 0, 16'h0000); // last without valid
    tbl[10] = mk(1, 0, 1, 0, 16'hFFFF, 16'h0000, 16'h0000, 0, 16'h0000); // care 0 passes
    tbl[11] = mk(1, 1, 1, 0, 16'hFFFF, 16'h0000, 16'hFFFF, 0, 16'h0000); // start drops vector
    tbl[12] = mk(1, 0, 1, 1, 16'h5555, 16'hAAAA, 16'hFFFF, 1, 16'hFFFF); // failing last

    for (int i = 0; i < 13; i++) applyStimulus(tbl[i], 1'b1);

    // Signature from zero: obs=0003 folds to 03, giving 06 after the rotate.
    applyStimulus(mk(1, 1, 0, 0, 16'h0, 16'h0, 16'h0, 0, 16'h0), 1'b0);
    applyStimulus(mk(1, 0, 1, 0, 16'h0003, 16'h0003, 16'hFFFF, 0, 16'h0), 1'b0);
    checkField("hashGolden", 32'(hash), 32'h06);
    applyStimulus(mk(1, 0, 1, 0, 16'h0081, 16'h0081, 16'hFFFF, 0, 16'h0), 1'b0);

    // Reset in the middle of a run, then vectors without start are ignored.
    applyStimulus(mk(1, 0, 1, 0, 16'h0001, 16'h0000, 16'h0001, 0, 16'h0), 1'b0);
    applyStimulus(mk(0, 0, 1, 0, 16'h0001, 16'h0000, 16'h0001, 0, 16'h0), 1'b0);
    applyStimulus(mk(1, 0, 1, 0, 16'h0001, 16'h0000, 16'h0001, 0, 16'h0), 1'b0);
    applyStimulus(mk(1, 0, 1, 1, 16'h0001, 16'h0000, 16'h0001, 0, 16'h0), 1'b0);
    checkField("idleVecCount", vec_count, 32'd0);
    checkField("idleBusy", 32'(busy), 32'd0);

    // First-error capture: failures at index 2 and 5.
    applyStimulus(mk(1, 1, 0, 0, 16'h0, 16'h0, 16'h0, 0, 16'h0), 1'b0);
    for (int i = 0; i < 6; i++)
      applyStimulus(mk(1, 0, 1, (i == 5), 16'h00F0, (i == 2 || i == 5) ? 16'h00F3 : 16'h00F0,
                       16'hFFFF, 0, 16'h0), 1'b0);
    applyStimulus(mk(1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 16'h0), 1'b0);
`ifdef TVCHK_FIRST_ERR_EN
    checkField("firstErrValid", 32'(feValid), 32'd1);
    checkField("firstErrIdx", feIdx, 32'd2);
    checkField("firstErrBits", 32'(feBits), 32'h0003);
`endif

    // Twenty failing vectors: the 4-bit counters stick at 15.
    applyStimulus(mk(1, 1, 0, 0, 16'h0, 16'h0, 16'h0, 0, 16'h0), 1'b0);
    for (int i = 0; i < 20; i++)
      applyStimulus(mk(1, 0, 1, (i == 19), 16'h0001, 16'h0000, 16'h0001, 0, 16'h0), 1'b0);
    checkField("satErrGolden", 32'(satEc), 32'hF);
    checkField("wideErrGolden", err_count, 32'd20);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
